// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's memory-side, redirect and decode-side signals.
// master = fetch stage, slave = environment (instruction memory + downstream).
interface if_stage_if #(
    parameter int IMEM_AW = 9,
    parameter int QDEPTH  = 2
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;

    logic               redirect_valid;
    logic [31:0]        redirect_pc;

    // out_valid/out_ready: a transfer happens in any cycle where both are high
    // at the rising edge; out_inst/out_pc/out_pc_4 stay stable while
    // out_valid is high and out_ready is low.
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_inst;
    logic [31:0]        out_pc;
    logic [31:0]        out_pc_4;
    logic [CW-1:0]      q_count;

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_inst, out_pc, out_pc_4, q_count,
        input  out_ready
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_inst, out_pc, out_pc_4, q_count,
        output out_ready
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, reads a synchronous-read imem and
// buffers returned words in a small prefetch queue with a valid/ready output.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 9,
    parameter int          QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    if_stage_if.master    bus
);
    localparam int            PW       = $clog2(QDEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL     = CW'(QDEPTH);
    localparam logic [CW:0]   FULL_EXT = {1'b0, FULL};

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   inst_q [QDEPTH];
    logic [31:0]   pc_q   [QDEPTH];

    logic          redirect;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   credit_used;
    logic          unused_redirect_lsbs;

    assign redirect = bus.redirect_valid;
    assign pop      = bus.out_valid & bus.out_ready;
    assign push     = inflight_q & ~redirect;

    // Credit check: queued + in-flight entries after this cycle's pop must
    // leave a slot for the word requested now, so a push never finds a full queue.
    assign credit_used = {1'b0, count_q}
                       + {{CW{1'b0}}, inflight_q}
                       - {{CW{1'b0}}, pop};
    assign issue = ~redirect & (credit_used < FULL_EXT);

    assign bus.imem_en   = issue;
    assign bus.imem_addr = fetch_pc_q[IMEM_AW+1:2];

    assign bus.out_valid = (count_q != '0);
    assign bus.out_inst  = inst_q[rd_ptr_q];
    assign bus.out_pc    = pc_q[rd_ptr_q];
    assign bus.out_pc_4  = pc_q[rd_ptr_q] + 32'd4;
    assign bus.q_count   = count_q;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect) begin
            // A pop this cycle is still a real handshake; the flush drops the rest.
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            inst_q[wr_ptr_q] <= bus.imem_rdata;
            pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!rst_n) push |-> (count_q != FULL)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run checked against
// a stream model (sequential PCs from the last reset/redirect target).
module tb_if_stage;
    localparam int          IMEM_AW = 9;
    localparam int          QDEPTH  = 2;
    localparam int          CW      = $clog2(QDEPTH) + 1;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    if_stage_if #(.IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH)) bus_a ();
    if_stage_if #(.IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH)) bus_b ();

    if_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    if_stage #(.RESET_PC(WRAP_PC), .IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    function automatic logic [31:0] mem_word(input logic [IMEM_AW-1:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    function automatic logic [31:0] inst_for_pc(input logic [31:0] pc);
        return mem_word(pc[IMEM_AW+1:2]);
    endfunction

    // Synchronous-read instruction memory: word k holds 32'h1000_0000 + k.
    always @(posedge clk) begin
        if (bus_a.imem_en) bus_a.imem_rdata <= mem_word(bus_a.imem_addr);
        if (bus_b.imem_en) bus_b.imem_rdata <= mem_word(bus_b.imem_addr);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus_a.out_ready      = 1'b0;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc    = '0;
        bus_b.out_ready      = 1'b0;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = '0;
    endtask

    // Leaves the bench at a falling edge with rst_n just released: cycle 0.
    task automatic reset_dut();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_exp(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(start + 32'(4 * k));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus_a.out_valid); end
        checks++; if (bus_a.q_count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", bus_a.q_count); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus_a.imem_en !== 1'b1) begin errors++; $display("FAIL rel_imem_en: got %b expected 1", bus_a.imem_en); end
        checks++; if (bus_a.imem_addr !== 9'h000) begin errors++; $display("FAIL rel_imem_addr: got %h expected 000", bus_a.imem_addr); end
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rel_valid: got %b expected 0", bus_a.out_valid); end
        checks++; if (bus_a.q_count !== '0) begin errors++; $display("FAIL rel_count: got %0d expected 0", bus_a.q_count); end
        checks++; if (bus_a.out_inst !== 32'h0) begin errors++; $display("FAIL rel_inst: got %h expected 0", bus_a.out_inst); end
        checks++; if (bus_a.out_pc !== 32'h0) begin errors++; $display("FAIL rel_pc: got %h expected 0", bus_a.out_pc); end
        checks++; if (bus_b.imem_addr !== 9'h1FE) begin errors++; $display("FAIL rel_b_addr: got %h expected 1fe", bus_b.imem_addr); end
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [31:0] e;
        reset_dut();
        bus_a.out_ready = 1'b1;
        fill_exp(32'h0, 32);
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            checks++;
            if (bus_a.out_valid !== (cyc >= 2)) begin errors++; $display("FAIL stream_valid c%0d: got %b expected %b", cyc, bus_a.out_valid, cyc >= 2); end
            if (bus_a.out_valid === 1'b1) begin
                if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hDEAD_BEEF;
                checks++; if (bus_a.out_pc !== e) begin errors++; $display("FAIL stream_pc c%0d: got %h expected %h", cyc, bus_a.out_pc, e); end
                checks++; if (bus_a.out_inst !== inst_for_pc(e)) begin errors++; $display("FAIL stream_inst c%0d: got %h expected %h", cyc, bus_a.out_inst, inst_for_pc(e)); end
                checks++; if (bus_a.out_pc_4 !== e + 32'd4) begin errors++; $display("FAIL stream_pc4 c%0d: got %h expected %h", cyc, bus_a.out_pc_4, e + 32'd4); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        logic [31:0] held_pc;
        held_pc = '0;
        reset_dut();
        fill_exp(32'h0, 32);
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus_a.out_ready = !(cyc >= 3 && cyc < 9);
            #1;
            if (cyc == 3) held_pc = bus_a.out_pc;
            if (cyc >= 2) begin
                checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b expected 1", cyc, bus_a.out_valid); end
            end
            if (cyc >= 4 && cyc < 9) begin
                checks++; if (bus_a.q_count !== CW'(QDEPTH)) begin errors++; $display("FAIL bp_count c%0d: got %0d expected %0d", cyc, bus_a.q_count, QDEPTH); end
                checks++; if (bus_a.imem_en !== 1'b0) begin errors++; $display("FAIL bp_imem_en c%0d: got %b expected 0", cyc, bus_a.imem_en); end
                checks++; if (bus_a.out_pc !== held_pc) begin errors++; $display("FAIL bp_hold c%0d: got %h expected %h", cyc, bus_a.out_pc, held_pc); end
            end
            if (bus_a.out_valid === 1'b1 && bus_a.out_ready) begin
                if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hDEAD_BEEF;
                checks++; if (bus_a.out_pc !== e) begin errors++; $display("FAIL bp_pc c%0d: got %h expected %h", cyc, bus_a.out_pc, e); end
                checks++; if (bus_a.out_inst !== inst_for_pc(e)) begin errors++; $display("FAIL bp_inst c%0d: got %h expected %h", cyc, bus_a.out_inst, inst_for_pc(e)); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_flush();
        logic [31:0] e;
        reset_dut();
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            if (cyc == 5) begin
                checks++; if (bus_a.q_count !== CW'(QDEPTH)) begin errors++; $display("FAIL rf_full: got %0d expected %0d", bus_a.q_count, QDEPTH); end
            end
            @(negedge clk);
        end
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = 32'h0000_0103;
        #1;
        checks++; if (bus_a.imem_en !== 1'b0) begin errors++; $display("FAIL rf_imem_en_r: got %b expected 0", bus_a.imem_en); end
        @(negedge clk);
        bus_a.redirect_valid = 1'b0;
        bus_a.out_ready      = 1'b1;
        fill_exp(32'h0000_0100, 16);
        for (int age = 1; age <= 7; age++) begin
            #1;
            if (age == 1) begin
                checks++; if (bus_a.imem_en !== 1'b1 || bus_a.imem_addr !== 9'h040) begin errors++; $display("FAIL rf_target_fetch: got en %b addr %h expected en 1 addr 040", bus_a.imem_en, bus_a.imem_addr); end
            end
            checks++;
            if (bus_a.out_valid !== (age >= 3)) begin errors++; $display("FAIL rf_valid r+%0d: got %b expected %b", age, bus_a.out_valid, age >= 3); end
            if (bus_a.out_valid === 1'b1) begin
                if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hDEAD_BEEF;
                checks++; if (bus_a.out_pc !== e) begin errors++; $display("FAIL rf_pc r+%0d: got %h expected %h", age, bus_a.out_pc, e); end
                checks++; if (bus_a.out_inst !== inst_for_pc(e)) begin errors++; $display("FAIL rf_inst r+%0d: got %h expected %h", age, bus_a.out_inst, inst_for_pc(e)); end
            end
            @(negedge clk);
        end
        bus_a.out_ready = 1'b0;
    endtask

    task automatic test_redirect_pop();
        logic [31:0] e;
        logic [31:0] rp;
        logic [31:0] tgt;
        rp  = $urandom;
        tgt = {rp[31:2], 2'b00};
        reset_dut();
        bus_a.out_ready = 1'b1;
        fill_exp(32'h0, 16);
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus_a.redirect_valid = (cyc == 5);
            bus_a.redirect_pc    = (cyc == 5) ? rp : 32'h0;
            #1;
            if (cyc == 5) begin
                checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 32'h0000_000C) begin errors++; $display("FAIL rp_head: got v%b pc %h expected v1 pc 0000000c", bus_a.out_valid, bus_a.out_pc); end
            end
            if (cyc == 6) begin
                checks++; if (bus_a.q_count !== '0) begin errors++; $display("FAIL rp_empty: got %0d expected 0", bus_a.q_count); end
            end
            if (cyc == 6 || cyc == 7) begin
                checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rp_gap c%0d: got %b expected 0", cyc, bus_a.out_valid); end
            end
            if (cyc == 8) begin
                checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== tgt) begin errors++; $display("FAIL rp_target: got v%b pc %h expected v1 pc %h", bus_a.out_valid, bus_a.out_pc, tgt); end
            end
            if (bus_a.out_valid === 1'b1) begin
                if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hDEAD_BEEF;
                checks++; if (bus_a.out_pc !== e) begin errors++; $display("FAIL rp_pc c%0d: got %h expected %h", cyc, bus_a.out_pc, e); end
                checks++; if (bus_a.out_inst !== inst_for_pc(e)) begin errors++; $display("FAIL rp_inst c%0d: got %h expected %h", cyc, bus_a.out_inst, inst_for_pc(e)); end
            end
            if (cyc == 5) fill_exp(tgt, 16);
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        reset_dut();
        bus_b.out_ready = 1'b1;
        fill_exp(WRAP_PC, 8);
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            if (cyc == 0) begin
                checks++; if (bus_b.imem_en !== 1'b1 || bus_b.imem_addr !== 9'h1FE) begin errors++; $display("FAIL wrap_addr0: got en %b addr %h expected en 1 addr 1fe", bus_b.imem_en, bus_b.imem_addr); end
            end
            if (cyc == 1) begin
                checks++; if (bus_b.imem_addr !== 9'h1FF) begin errors++; $display("FAIL wrap_addr1: got %h expected 1ff", bus_b.imem_addr); end
            end
            if (cyc == 2) begin
                checks++; if (bus_b.imem_addr !== 9'h000) begin errors++; $display("FAIL wrap_addr2: got %h expected 000", bus_b.imem_addr); end
            end
            checks++;
            if (bus_b.out_valid !== (cyc >= 2)) begin errors++; $display("FAIL wrap_valid c%0d: got %b expected %b", cyc, bus_b.out_valid, cyc >= 2); end
            if (bus_b.out_valid === 1'b1) begin
                if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hDEAD_BEEF;
                checks++; if (bus_b.out_pc !== e) begin errors++; $display("FAIL wrap_pc c%0d: got %h expected %h", cyc, bus_b.out_pc, e); end
                checks++; if (bus_b.out_inst !== inst_for_pc(e)) begin errors++; $display("FAIL wrap_inst c%0d: got %h expected %h", cyc, bus_b.out_inst, inst_for_pc(e)); end
                checks++; if (bus_b.out_pc_4 !== e + 32'd4) begin errors++; $display("FAIL wrap_pc4 c%0d: got %h expected %h", cyc, bus_b.out_pc_4, e + 32'd4); end
            end
            @(negedge clk);
        end
        bus_b.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] e;
        reset_dut();
        repeat (5) @(negedge clk);
        #1;
        checks++; if (bus_a.q_count !== CW'(QDEPTH)) begin errors++; $display("FAIL ar_full: got %0d expected %0d", bus_a.q_count, QDEPTH); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", bus_a.out_valid); end
        checks++; if (bus_a.q_count !== '0) begin errors++; $display("FAIL ar_count: got %0d expected 0", bus_a.q_count); end
        checks++; if (bus_a.out_pc !== 32'h0) begin errors++; $display("FAIL ar_pc: got %h expected 0", bus_a.out_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        fill_exp(32'h0, 16);
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            if (cyc == 0) begin
                checks++; if (bus_a.imem_en !== 1'b1 || bus_a.imem_addr !== 9'h000) begin errors++; $display("FAIL ar_restart: got en %b addr %h expected en 1 addr 000", bus_a.imem_en, bus_a.imem_addr); end
            end
            checks++;
            if (bus_a.out_valid !== (cyc >= 2)) begin errors++; $display("FAIL ar_valid c%0d: got %b expected %b", cyc, bus_a.out_valid, cyc >= 2); end
            if (bus_a.out_valid === 1'b1) begin
                if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 32'hDEAD_BEEF;
                checks++; if (bus_a.out_pc !== e) begin errors++; $display("FAIL ar_pc c%0d: got %h expected %h", cyc, bus_a.out_pc, e); end
                checks++; if (bus_a.out_inst !== inst_for_pc(e)) begin errors++; $display("FAIL ar_inst c%0d: got %h expected %h", cyc, bus_a.out_inst, inst_for_pc(e)); end
            end
            @(negedge clk);
        end
        bus_a.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] next_pc;
        logic [31:0] fetch_exp;
        logic [31:0] rp;
        logic [31:0] tgt;
        logic        redir;
        int          age;
        int          cooldown;
        reset_dut();
        next_pc   = 32'h0;
        fetch_exp = 32'h0;
        age       = 100;
        cooldown  = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            redir = (cooldown == 0) && ($urandom_range(0, 15) == 0);
            rp    = $urandom;
            tgt   = {rp[31:2], 2'b00};
            bus_a.out_ready      = ($urandom_range(0, 3) != 0);
            bus_a.redirect_valid = redir;
            bus_a.redirect_pc    = rp;
            #1;
            checks++; if (bus_a.q_count > CW'(QDEPTH)) begin errors++; $display("FAIL rnd_count c%0d: got %0d expected <= %0d", cyc, bus_a.q_count, QDEPTH); end
            checks++; if (bus_a.out_valid !== (bus_a.q_count != '0)) begin errors++; $display("FAIL rnd_valid_count c%0d: got v%b count %0d", cyc, bus_a.out_valid, bus_a.q_count); end
            if (redir) begin
                checks++; if (bus_a.imem_en !== 1'b0) begin errors++; $display("FAIL rnd_redir_en c%0d: got %b expected 0", cyc, bus_a.imem_en); end
            end
            if (age == 1 || age == 2) begin
                checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rnd_gap c%0d: got %b expected 0", cyc, bus_a.out_valid); end
            end
            if (age == 3) begin
                checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL rnd_arrive c%0d: got %b expected 1", cyc, bus_a.out_valid); end
            end
            if (bus_a.q_count == CW'(QDEPTH) && !(bus_a.out_valid && bus_a.out_ready)) begin
                checks++; if (bus_a.imem_en !== 1'b0) begin errors++; $display("FAIL rnd_full_en c%0d: got %b expected 0", cyc, bus_a.imem_en); end
            end
            if (bus_a.imem_en === 1'b1) begin
                checks++; if (bus_a.imem_addr !== fetch_exp[IMEM_AW+1:2]) begin errors++; $display("FAIL rnd_addr c%0d: got %h expected %h", cyc, bus_a.imem_addr, fetch_exp[IMEM_AW+1:2]); end
                fetch_exp = fetch_exp + 32'd4;
            end
            if (bus_a.out_valid === 1'b1 && bus_a.out_ready) begin
                checks++; if (bus_a.out_pc !== next_pc) begin errors++; $display("FAIL rnd_pc c%0d: got %h expected %h", cyc, bus_a.out_pc, next_pc); end
                checks++; if (bus_a.out_inst !== inst_for_pc(next_pc)) begin errors++; $display("FAIL rnd_inst c%0d: got %h expected %h", cyc, bus_a.out_inst, inst_for_pc(next_pc)); end
                checks++; if (bus_a.out_pc_4 !== next_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4 c%0d: got %h expected %h", cyc, bus_a.out_pc_4, next_pc + 32'd4); end
                next_pc = next_pc + 32'd4;
            end
            if (redir) begin
                next_pc   = tgt;
                fetch_exp = tgt;
                age       = 1;
                cooldown  = int'($urandom_range(4, 12));
            end else begin
                if (age < 100) age++;
                if (cooldown > 0) cooldown--;
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        drive_idle();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage that sits directly upstream of the decode/execute datapath. It owns the fetch PC and issues word reads to a synchronous-read instruction memory. Returned instructions are buffered in a small prefetch queue and presented downstream with a valid/ready handshake, together with their PC and PC+4. Downstream branch/jump resolution redirects the fetch PC and flushes all buffered and in-flight instructions.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- IMEM_AW, 9, instruction memory word-address width
- QDEPTH, 2, prefetch queue entries (power of two, ≥2)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_en  out  1  read request this cycle
- imem_addr  out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]
- imem_rdata  in  32  read data, valid the cycle after imem_en
- redirect_valid  in  1  load new fetch PC and flush
- redirect_pc  in  32  redirect target (bits [1:0] ignored, treated as 0)
- out_valid  out  1  queue head holds an instruction
- out_ready  in  1  downstream accepts head
- out_inst  out  32  head instruction
- out_pc  out  32  head instruction address
- out_pc_4  out  32  out_pc + 4 (mod 2^32)
- q_count  out  $clog2(QDEPTH)+1  entries currently in queue

## Operation
- State: fetch_pc (32b), inflight flag + inflight_pc, queue of {inst, pc} with rd/wr pointers and count.
- pop = out_valid & out_ready.
- Issue condition: !redirect_valid & (count + inflight − pop < QDEPTH). On issue: imem_en=1, imem_addr from fetch_pc; at edge, inflight←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+4 (wraps 32'hFFFF_FFFC→0). No issue: imem_en=0, inflight←0.
- Response: when inflight=1 and no redirect, push {imem_rdata, inflight_pc} at the edge. Credit rule guarantees no push to a full queue; push to full is an assertion failure.
- Simultaneous push and pop: count unchanged, both pointers advance; pop from a queue of count 1 with push keeps out_valid high.
- Redirect (redirect_valid=1): at edge, fetch_pc←{redirect_pc[31:2],2'b00}, count←0, pointers←0, inflight←0; in-flight response discarded; imem_en=0 that cycle. A pop in the same cycle is still a valid handshake (head consumed), then flushed.
- Outputs out_inst/out_pc/out_pc_4 driven from queue head; values undefined-but-stable-within-cycle when out_valid=0 (drive head entry).
- Reset (async): fetch_pc←RESET_PC, count/pointers/inflight←0. Reset values: out_valid=0, q_count=0, imem_en combinational (1 in first cycle after release), out_* = 0 (queue storage cleared).

## Timing
- Fetch latency: imem_en in cycle N → entry pushed at edge ending N+1 → out_valid in N+2.
- After rst_n release: imem_en=1 for RESET_PC in cycle 0; out_valid=1 from cycle 2.
- Redirect in cycle R: imem_en=0 in R; imem_en for target in R+1; out_valid with out_pc=target in R+3; out_valid=0 in R+1..R+2.
- Steady state with out_ready=1: one instruction per cycle, consecutive PCs.
- Backpressure: out_ready=0 holds head stable; queue fills to QDEPTH, then imem_en=0 until a pop; no instruction lost or duplicated.
- Reset mid-operation: all state cleared immediately, in-flight response ignored.

## Test plan
- Reset streaming: imem word k = 32'h1000_0000+k, out_ready=1 → out_valid from cycle 2, out_pc 0,4,8,… one per cycle, out_inst matches, out_pc_4 = out_pc+4.
- Backpressure: out_ready=0 from cycle 3 for 6 cycles → q_count saturates at 2, imem_en=0 while full, head stable; on release sequence resumes with no gap or duplicate.
- Redirect flush: redirect_valid pulse with redirect_pc=32'h0000_0103 mid-stream → no out_valid for 2 cycles, next out_pc=32'h100, prior queued entries never appear.
- Redirect with handshake: redirect_valid and pop in same cycle → popped instruction counted once, queue empty next cycle, target arrives at R+3.
- PC wrap: RESET_PC=32'hFFFF_FFF8 → out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; imem_addr wraps to 0.
- Async reset mid-run: drop rst_n between edges with queue full → out_valid and q_count 0 immediately; restart fetches from RESET_PC.
